// File: rtl/uart_rom_loader_if.sv
// Bus between the UART byte receiver, the ROM loader and the instruction ROM / CPU control.
// No backpressure: rx_valid and rom_we are one-cycle strobes that are consumed on the clk edge where they are high. There is no ready signal.
interface uart_rom_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_break;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [15:0]           rom_wdata;
  logic                  rom_we;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;
  logic [ADDR_WIDTH:0]   words_loaded;

  modport master (
    output rx_data, rx_valid, rx_break,
    input  rom_addr, rom_wdata, rom_we, cpu_hold, load_done, load_error, words_loaded
  );

  modport slave (
    input  rx_data, rx_valid, rx_break,
    output rom_addr, rom_wdata, rom_we, cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/uart_rom_loader.sv
// Parses a framed boot image from the UART byte stream and writes 16-bit words into instruction ROM.
// Define LOADER_CHECKSUM_EN to expect the trailing CHK byte. Without it, a frame ends after its last data word.
module uart_rom_loader #(
  parameter int         ADDR_WIDTH     = 15,
  parameter int         ROM_DEPTH      = 32768,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                resetn,
  uart_rom_loader_if.slave    bus,
  output logic [2:0]          o_dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_len;
  logic [7:0]            r_hi;
  logic [ADDR_WIDTH:0]   r_words;
  logic [TW-1:0]         r_timer;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic [15:0]           r_rom_wdata;
  logic                  r_rom_we;
  logic                  r_done;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_chk;
`endif

  logic        w_hold;
  logic        w_take;
  logic        w_start;
  logic        w_write;
  logic        w_last;
  logic [15:0] w_len;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_write = 1'b0;
    w_hold  = r_state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    // A break on the same cycle as a byte drops the byte.
    w_take  = w_hold && bus.rx_valid && !bus.rx_break;
    w_len   = {r_len[15:8], bus.rx_data};
    w_last  = (32'(r_words) + 32'd1) == 32'(r_len);

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
          w_next  = S_LEN_HI;
          w_start = 1'b1;
        end
      end
      S_LEN_HI: if (w_take) w_next = S_LEN_LO;
      S_LEN_LO: begin
        if (w_take) begin
          if ({16'd0, w_len} > 32'(ROM_DEPTH)) w_next = S_ERROR;
`ifdef LOADER_CHECKSUM_EN
          else if (w_len == 16'd0) w_next = S_CHECK;
`else
          else if (w_len == 16'd0) w_next = S_DONE;
`endif
          else w_next = S_DATA_HI;
        end
      end
      S_DATA_HI: if (w_take) w_next = S_DATA_LO;
      S_DATA_LO: begin
        if (w_take) begin
          w_write = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          w_next  = w_last ? S_CHECK : S_DATA_HI;
`else
          w_next  = w_last ? S_DONE : S_DATA_HI;
`endif
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (w_take) w_next = (bus.rx_data == r_chk) ? S_DONE : S_ERROR;
`endif
      end
      default: w_next = S_IDLE;
    endcase

    // A byte arriving on the timeout cycle keeps the frame alive.
    if (w_hold && (bus.rx_break || (!bus.rx_valid && r_timer == TIMER_LAST))) begin
      w_next  = S_ERROR;
      w_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_hi        <= '0;
      r_words     <= '0;
      r_timer     <= '0;
      r_rom_addr  <= '0;
      r_rom_wdata <= '0;
      r_rom_we    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_chk       <= '0;
`endif
    end else begin
      r_state  <= w_next;
      r_rom_we <= w_write;
      r_done   <= (w_next == S_DONE);
      r_error  <= (w_next == S_ERROR);

      if (!w_hold || bus.rx_valid) r_timer <= '0;
      else                         r_timer <= r_timer + 1'b1;

      if (w_start) begin
        r_words <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_chk   <= '0;
`endif
      end

      if (w_take) begin
        case (r_state)
          S_LEN_HI:  r_len[15:8] <= bus.rx_data;
          S_LEN_LO:  r_len[7:0]  <= bus.rx_data;
          S_DATA_HI: r_hi        <= bus.rx_data;
          default: ;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (r_state != S_CHECK) r_chk <= r_chk + bus.rx_data;
`endif
      end

      if (w_write) begin
        r_rom_addr  <= r_words[ADDR_WIDTH-1:0];
        r_rom_wdata <= {r_hi, bus.rx_data};
        r_words     <= r_words + 1'b1;
      end
    end
  end

  assign bus.rom_addr     = r_rom_addr;
  assign bus.rom_wdata    = r_rom_wdata;
  assign bus.rom_we       = r_rom_we;
  assign bus.cpu_hold     = w_hold;
  assign bus.load_done    = r_done;
  assign bus.load_error   = r_error;
  assign bus.words_loaded = r_words;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Bench for uart_rom_loader: directed frames plus random frames against a frame-level parser model.
module tb_uart_rom_loader;
  localparam int AW    = 15;
  localparam int DEPTH = 32768;
  localparam int TO    = 64;
  localparam int W     = AW + 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] dbg_state;
  int         checks = 0;
  int         errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic         m_done, m_err;
  int           m_words;
  logic         prev_hold = 1'b0, prev_done = 1'b0, prev_error = 1'b0;

  uart_rom_loader_if #(.ADDR_WIDTH(AW)) bus();

  uart_rom_loader #(
    .ADDR_WIDTH(AW), .ROM_DEPTH(DEPTH), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Scoreboard: every ROM write must match the head of the expected queue.
  always @(negedge clk) begin
    if (bus.rom_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rom_write unexpected addr=%0h data=%0h", bus.rom_addr, bus.rom_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({bus.rom_addr, bus.rom_wdata} !== mon_exp) begin
          errors++;
          $display("FAIL rom_write got=%0h want=%0h", {bus.rom_addr, bus.rom_wdata}, mon_exp);
        end
      end
    end
    if ((bus.load_done === 1'b1 && !prev_done) || (bus.load_error === 1'b1 && !prev_error)) begin
      checks++;
      if (!(prev_hold === 1'b1 && bus.cpu_hold === 1'b0)) begin
        errors++;
        $display("FAIL hold_edge prev_hold=%b hold=%b want 1 then 0", prev_hold, bus.cpu_hold);
      end
    end
    prev_hold  = bus.cpu_hold;
    prev_done  = bus.load_done;
    prev_error = bus.load_error;
  end

  // Frame-level reference: walks a byte stream and derives writes and final status.
  task automatic model_stream(input logic [7:0] s[$]);
    int i;
    int n;
    logic [7:0] sum;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin
        i++;
        continue;
      end
      i++;
      m_done = 1'b0; m_err = 1'b0; m_words = 0;
      if (i + 2 > s.size()) begin
        m_err = 1'b1;
        i = s.size();
        continue;
      end
      n = int'({s[i], s[i+1]});
      sum = s[i] + s[i+1];
      i += 2;
      if (n > DEPTH) begin
        m_err = 1'b1;
        continue;
      end
      for (int k = 0; k < n && !m_err; k++) begin
        if (i + 2 > s.size()) begin
          m_err = 1'b1;
          i = s.size();
        end else begin
          exp_q.push_back({AW'(k), s[i], s[i+1]});
          sum = sum + s[i] + s[i+1];
          m_words++;
          i += 2;
        end
      end
      if (m_err) continue;
`ifdef LOADER_CHECKSUM_EN
      if (i >= s.size()) begin
        m_err = 1'b1;
        continue;
      end
      if (s[i] == sum) m_done = 1'b1;
      else m_err = 1'b1;
      i++;
`else
      m_done = 1'b1;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input logic brk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    bus.rx_break = brk;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_stream(input logic [7:0] s[$], input int gap_max);
    foreach (s[j]) send_byte(s[j], $urandom_range(0, gap_max), 1'b0);
  endtask

  task automatic do_reset;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.rx_break = 1'b0;
    resetn       = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({bus.rom_addr, bus.rom_wdata, bus.rom_we, bus.cpu_hold, bus.load_done,
         bus.load_error, bus.words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got addr=%0h data=%0h we=%b hold=%b done=%b err=%b words=%0d want all 0",
               bus.rom_addr, bus.rom_wdata, bus.rom_we, bus.cpu_hold, bus.load_done,
               bus.load_error, bus.words_loaded);
    end
  endtask

  task automatic test_nominal;
    logic [7:0] s[$];
    int lo_idx;
`ifdef LOADER_CHECKSUM_EN
    s = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    lo_idx = 6;
`else
    s = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
    lo_idx = 4;
`endif
    model_stream(s);
    foreach (s[j]) begin
      send_byte(s[j], 0, 1'b0);
      if (j == lo_idx) begin
        checks++;
        if (bus.rom_we !== 1'b1) begin
          errors++;
          $display("FAIL nominal_we_latency got=%b want=1", bus.rom_we);
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold} !==
        {m_done, m_err, (AW+1)'(m_words), 1'b0} || m_done !== 1'b1) begin
      errors++;
      $display("FAIL nominal_status got done=%b err=%b words=%0d hold=%b want done=%b err=%b words=%0d hold=0",
               bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold, m_done, m_err, m_words);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL nominal_writes_missing got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_tail;
    logic [7:0] s[$];
`ifdef LOADER_CHECKSUM_EN
    s = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
`else
    s = '{8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h3C};
`endif
    model_stream(s);
    drive_stream(s, 1);
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold} !==
        {m_done, m_err, (AW+1)'(m_words), 1'b0}) begin
      errors++;
      $display("FAIL tail_status got done=%b err=%b words=%0d want done=%b err=%b words=%0d",
               bus.load_done, bus.load_error, bus.words_loaded, m_done, m_err, m_words);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL tail_writes_missing got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    logic [7:0] s[$];
    s = '{8'hA5, 8'h00, 8'h01, 8'h12};
    model_stream(s);
    send_byte(s[0], TO - 8, 1'b0);
    send_byte(s[1], TO - 8, 1'b0);
    checks++;
    if (bus.load_error !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early got err=%b hold=%b want err=0 hold=1", bus.load_error, bus.cpu_hold);
    end
    send_byte(s[2], 0, 1'b0);
    send_byte(s[3], 0, 1'b0);
    repeat (TO + 10) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.cpu_hold} !== {m_done, m_err, 1'b0} || m_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_status got done=%b err=%b hold=%b want done=0 err=1 hold=0",
               bus.load_done, bus.load_error, bus.cpu_hold);
    end
`ifdef LOADER_CHECKSUM_EN
    s = '{8'hA5, 8'h00, 8'h00, 8'h00};
`else
    s = '{8'hA5, 8'h00, 8'h00};
`endif
    model_stream(s);
    drive_stream(s, 2);
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.words_loaded} !== {m_done, m_err, (AW+1)'(m_words)} ||
        m_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover got done=%b err=%b words=%0d want done=1 err=0 words=0",
               bus.load_done, bus.load_error, bus.words_loaded);
    end
  endtask

  task automatic test_oversize;
    logic [7:0] s[$];
    s = '{8'h3C, 8'h7F, 8'hA5, 8'h80, 8'h01};
    model_stream(s);
    drive_stream(s, 1);
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold} !==
        {m_done, m_err, (AW+1)'(m_words), 1'b0} || m_err !== 1'b1) begin
      errors++;
      $display("FAIL oversize_status got done=%b err=%b words=%0d hold=%b want done=0 err=1 words=0 hold=0",
               bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold);
    end
    // Exactly ROM_DEPTH words is a legal length; leaves the loader mid-frame.
    s = '{8'hA5, 8'h80, 8'h00};
    drive_stream(s, 0);
    checks++;
    if (bus.load_error !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL depth_boundary got err=%b hold=%b want err=0 hold=1", bus.load_error, bus.cpu_hold);
    end
  endtask

  task automatic test_reset_mid;
    exp_q.push_back({AW'(0), 16'h1234});
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    send_byte(8'hAB, 0, 1'b0);
    bus.rx_data  = 8'hCD;
    bus.rx_valid = 1'b1;
    resetn       = 1'b0;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    checks++;
    if ({bus.rom_addr, bus.rom_wdata, bus.rom_we, bus.cpu_hold, bus.load_done,
         bus.load_error, bus.words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_mid got addr=%0h data=%0h we=%b hold=%b done=%b err=%b words=%0d want all 0",
               bus.rom_addr, bus.rom_wdata, bus.rom_we, bus.cpu_hold, bus.load_done,
               bus.load_error, bus.words_loaded);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.rom_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_writes got pending=%0d we=%b want 0 0", exp_q.size(), bus.rom_we);
    end
  endtask

  task automatic test_break;
    logic [7:0] s[$];
    s = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    exp_q.push_back({AW'(0), 16'h1234});
    drive_stream(s, 1);
    send_byte(8'hCD, 0, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold} !== {1'b0, 1'b1, (AW+1)'(1), 1'b0}) begin
      errors++;
      $display("FAIL break_status got done=%b err=%b words=%0d hold=%b want done=0 err=1 words=1 hold=0",
               bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL break_writes_missing got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_random;
    logic [7:0] s[$];
    logic [7:0] b, sum;
    int n;
    for (int f = 0; f < 20; f++) begin
      s = {};
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC) b = 8'h00;
        s.push_back(b);
      end
      s.push_back(SYNC);
      if ($urandom_range(0, 9) == 0) begin
        s.push_back(8'($urandom_range(128, 255)));
        s.push_back(8'($urandom_range(1, 255)));
      end else begin
        n = $urandom_range(0, 5);
        s.push_back(8'h00);
        s.push_back(8'(n));
        sum = 8'(n);
        for (int k = 0; k < 2 * n; k++) begin
          b = 8'($urandom_range(0, 255));
          s.push_back(b);
          sum = sum + b;
        end
`ifdef LOADER_CHECKSUM_EN
        if ($urandom_range(0, 3) == 0) sum = sum ^ 8'($urandom_range(1, 255));
        s.push_back(sum);
`endif
      end
      model_stream(s);
      drive_stream(s, 3);
      repeat (4) @(negedge clk);
      checks++;
      if ({bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold} !==
          {m_done, m_err, (AW+1)'(m_words), 1'b0}) begin
        errors++;
        $display("FAIL random_status frame=%0d got done=%b err=%b words=%0d hold=%b want done=%b err=%b words=%0d",
                 f, bus.load_done, bus.load_error, bus.words_loaded, bus.cpu_hold, m_done, m_err, m_words);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_writes_missing frame=%0d got=%0d want=0", f, exp_q.size());
        exp_q = {};
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_tail();
    test_timeout();
    test_oversize();
    test_reset_mid();
    test_break();
    test_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rom_loader.md
Name: uart_rom_loader

Overview:
Downstream consumer of the UART receiver's byte stream (data / is_valid / got_break). Parses a framed boot image and writes 16-bit Hack instruction words into instruction ROM. Holds the CPU in reset while a load is in progress and reports done or error.

Parameters:
ADDR_WIDTH, 15, ROM address width in words.
ROM_DEPTH, 32768, maximum accepted word count; must be ≤ 2**ADDR_WIDTH.
SYNC_BYTE, 8'hA5, frame start marker.
TIMEOUT_CYCLES, 5_000_000, maximum clk cycles between bytes inside a frame (100 ms at 50 MHz).

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
rx_data  in  8  received byte, qualified by rx_valid
rx_valid  in  1  one-cycle strobe, byte available
rx_break  in  1  break/framing error from receiver
rom_addr  out  ADDR_WIDTH  ROM write address
rom_wdata  out  16  ROM write data
rom_we  out  1  one-cycle ROM write strobe
cpu_hold  out  1  hold CPU in reset while loading
load_done  out  1  last frame completed successfully
load_error  out  1  last frame aborted
words_loaded  out  ADDR_WIDTH+1  words written in the current or last frame

Behaviour:
- Reset is synchronous: when resetn=0 on a clk edge, all outputs are 0, FSM goes to IDLE, and internal counters clear.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N words as (HI byte, LO byte), then CHK.
- N = {LEN_HI, LEN_LO}. Bytes are consumed only on cycles with rx_valid=1.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR.
- IDLE / DONE / ERROR: a byte equal to SYNC_BYTE goes to LEN_HI and clears load_done, load_error, words_loaded and the checksum. Any other byte is ignored.
- LEN_HI → LEN_LO on a byte.
- LEN_LO on a byte:
  - if N > ROM_DEPTH → ERROR;
  - if N == 0 → CHECK;
  - otherwise → DATA_HI.
- DATA_HI: latch the high byte, then → DATA_LO.
- DATA_LO on a byte, in the next cycle:
  - rom_we=1 for exactly one cycle;
  - rom_wdata = {hi, lo};
  - rom_addr = words_loaded (old value), starting at 0;
  - words_loaded increments in the same cycle.
  - Then → CHECK if words_loaded+1 == N, else → DATA_HI.
- Latency: rom_we is asserted the cycle after the rx_valid of the LO byte.
- Checksum: 8-bit wrapping sum of LEN_HI, LEN_LO and all data bytes; SYNC_BYTE and CHK are excluded.
- CHECK on a byte: equal to the checksum → DONE, else → ERROR.
- DONE: load_done=1, held until the next SYNC_BYTE.
- ERROR: load_error=1, held until the next SYNC_BYTE.
- ROM writes already made in an aborted frame are not undone.
- cpu_hold=1 in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; 0 otherwise.
- cpu_hold deasserts in the same cycle load_done or load_error rises.
- Timeout: a cycle counter clears on every rx_valid and in IDLE/DONE/ERROR. In any other state, reaching TIMEOUT_CYCLES-1 → ERROR.
- rx_break in any hold state → ERROR.
- Simultaneous events:
  - rx_break with rx_valid: break wins and the byte is dropped;
  - rx_valid on the timeout cycle: the byte wins and the timeout does not fire;
  - rx_break in IDLE/DONE/ERROR: ignored.
- rom_addr and rom_wdata hold their last values when rom_we=0.
- Reset mid-frame aborts immediately. No rom_we is issued on the reset cycle or after it; all flags are 0.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: the CHK byte and CHECK state exist as described above.
- Undefined: no CHK byte and no checksum logic.
  - The last DATA_LO goes directly to DONE.
  - N == 0 goes directly to DONE from LEN_LO.
  - A trailing byte is then treated as an IDLE-style byte, i.e. ignored unless it is SYNC_BYTE.

Test Plan:
- Nominal load, checksum enabled: bytes A5 00 02 12 34 AB CD C0.
  - rom_we pulses at addr 0 data 16'h1234, then at addr 1 data 16'hABCD.
  - load_done=1, load_error=0, words_loaded=2, cpu_hold falls with load_done.
- Bad checksum: same frame with CHK=C1 → load_error=1, load_done=0, both words still written.
- Timeout: A5 00 01 12, then silence for TIMEOUT_CYCLES → load_error=1, no rom_we, cpu_hold=0.
  - A following complete frame (A5 00 00 00) → load_done=1, load_error=0.
- Oversize and noise:
  - bytes 3C 7F A5 (3C and 7F ignored in IDLE), then 80 01 (N=32769 > ROM_DEPTH) → load_error=1 after LEN_LO, no rom_we.
- Break and reset:
  - rx_break during DATA_LO together with rx_valid → load_error=1, no write for that word.
  - Separately, resetn=0 mid-frame → all outputs 0 on the next edge.
- Macro undefined: A5 00 01 BE EF → single write of 16'hBEEF at addr 0 and load_done=1 with no CHK byte.
